stall_monitor: RTL and testbench
================================

STALL_MONITOR -- requirements
Module: stall_monitor

Interface
REQ-001 Parameter MAX_STALL, default 2: maximum legal consecutive hazard-stall cycles.
REQ-002 Parameter CNT_W, default 16: width of all event and cycle counters.
REQ-003 Parameter HALT_ON_ERR, default 1: when 1, counters freeze after the first error.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 opcode_id  in  7  opcode of the instruction in ID.
REQ-007 rs1_id, rs2_id  in  5 each  source registers of the instruction in ID.
REQ-008 opcode_ex, rd_ex  in  7 / 5  opcode and destination of the instruction in EX (bubble = opcode 0).
REQ-009 opcode_mem, rd_mem  in  7 / 5  opcode and destination of the instruction in MEM.
REQ-010 stall  in  1  pipeline stall observed in ID.
REQ-011 stall_ext  in  1  stall from a legitimate non-hazard source (divider, memory wait).
REQ-012 err_missing, err_spurious, err_overrun  out  1 each  sticky error flags.
REQ-013 err_any  out  1  OR of the three error flags.
REQ-014 first_err_cycle  out  CNT_W  cycle count at which the first error was latched.
REQ-015 stall_cycles, stall_events  out  CNT_W each  total stall cycles; number of stall runs started.
REQ-016 max_run  out  4  longest hazard-stall run seen, saturating at 15.

Function
REQ-017 rs1 is used by every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
REQ-018 rs2 is used only by R 0110011, S 0100011, B 1100011 and AMO 0101111.
REQ-019 A match requires rd != 0 and rd equal to a used source; x0 never creates a hazard.
REQ-020 H_LOAD: opcode_ex = LOAD 0000011 with a match against ID.
REQ-021 H_BR_EX: ID is B or JALR 1100111; EX is R, I-ALU 0010011, LUI, AUIPC, JAL or JALR; match against ID.
REQ-022 H_BR_MEM: ID is B or JALR; opcode_mem = LOAD; match of rd_mem against ID.
REQ-023 hazard = H_LOAD | H_BR_EX | H_BR_MEM, evaluated combinationally each cycle.
REQ-024 err_missing sets one cycle after any cycle with hazard=1 and stall=0.
REQ-025 err_spurious sets one cycle after any cycle with stall=1, hazard=0 and stall_ext=0.
REQ-026 run_len counts consecutive cycles with stall=1 and stall_ext=0; it clears on any other cycle.
REQ-027 err_overrun sets one cycle after run_len reaches MAX_STALL+1.
REQ-028 stall_ext=1 together with stall=1 is never an error and holds run_len unchanged.
REQ-029 FSM states: MON_IDLE, MON_RUN, MON_HALT.
REQ-030 IDLE->RUN on stall=1 and stall_ext=0, which increments stall_events.
REQ-031 RUN->IDLE on stall=0.
REQ-032 Any state goes to HALT on the first error when HALT_ON_ERR=1; HALT exits only via reset.
REQ-033 stall_cycles increments every cycle with stall=1 while not in HALT.
REQ-034 The internal cycle counter increments every cycle while not in HALT.
REQ-035 All counters saturate at all-ones and never wrap.
REQ-036 max_run updates to run_len whenever run_len exceeds it.
REQ-037 first_err_cycle loads the cycle counter value only on the first error; later errors do not change it.
REQ-038 Errors of different types in the same cycle all set; first_err_cycle records that cycle.
REQ-039 When HALT_ON_ERR=0, counters keep running after an error and error flags remain sticky.

Reset
REQ-040 While reset=0 at a rising edge, all flags, counters, run_len and max_run become 0 and the FSM enters MON_IDLE.
REQ-041 A reset mid-run discards the partial run; no error is flagged for the reset cycle.

Verification
REQ-042 opcode_ex=LOAD, rd_ex=5; opcode_id=R, rs2_id=5; stall=1 for 1 cycle -> no error, stall_events=1, max_run=1.
REQ-043 Same hazard with stall=0 -> err_missing=1 next cycle, first_err_cycle=cycle of the hazard, counters frozen.
REQ-044 B in ID with LOAD rd=3 in EX, rs1_id=3; 2 stall cycles with the LOAD moving to MEM -> no error, max_run=2.
REQ-045 stall=1 for 3 cycles, stall_ext=0, hazard held -> err_overrun=1 after the 3rd cycle.
REQ-046 JAL in ID, no hazard, stall=1, stall_ext=0 -> err_spurious=1; repeated with stall_ext=1 -> no error.
REQ-047 rd_ex=0 LOAD, rs1_id=0, stall=0 -> no error; apply reset during a 2-cycle run -> all outputs 0, MON_IDLE.

Source files
------------

// File: rtl/stall_monitor.sv
// Pipeline stall monitor: recomputes the expected RAW hazard for the instruction in ID
// and flags missing, spurious and over-long stalls, with saturating statistics counters.
module stall_monitor #(
  parameter int unsigned MaxStall  = 2,
  parameter int unsigned CntW      = 16,
  parameter bit          HaltOnErr = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [6:0]      opcode_id_i,
  input  logic [4:0]      rs1_id_i,
  input  logic [4:0]      rs2_id_i,
  input  logic [6:0]      opcode_ex_i,
  input  logic [4:0]      rd_ex_i,
  input  logic [6:0]      opcode_mem_i,
  input  logic [4:0]      rd_mem_i,
  input  logic            stall_i,
  input  logic            stall_ext_i,
  output logic            err_missing_o,
  output logic            err_spurious_o,
  output logic            err_overrun_o,
  output logic            err_any_o,
  output logic [CntW-1:0] first_err_cycle_o,
  output logic [CntW-1:0] stall_cycles_o,
  output logic [CntW-1:0] stall_events_o,
  output logic [3:0]      max_run_o
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpAmo   = 7'b0101111;
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpJal   = 7'b1101111;

  typedef enum logic [1:0] {MonIdle, MonRun, MonHalt} mon_state_e;

  mon_state_e      state_q, state_d;
  logic            err_missing_q, err_missing_d;
  logic            err_spurious_q, err_spurious_d;
  logic            err_overrun_q, err_overrun_d;
  logic [CntW-1:0] first_err_q, first_err_d;
  logic [CntW-1:0] stall_cycles_q, stall_cycles_d;
  logic [CntW-1:0] stall_events_q, stall_events_d;
  logic [CntW-1:0] cycle_q, cycle_d;
  logic [CntW-1:0] run_len_q, run_len_d;
  logic [3:0]      max_run_q, max_run_d;

  logic rs1_used, rs2_used, id_is_br, ex_is_alu;
  logic match_ex, match_mem, hazard;
  logic halted, hz_stall, miss_now, spur_now, ovr_now, new_err;
  logic [3:0] run_clip;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + CntW'(1);
  endfunction

  // Hazard decode for the instruction currently in ID.
  always_comb begin
    rs1_used  = !(opcode_id_i inside {OpLui, OpAuipc, OpJal});
    rs2_used  = opcode_id_i inside {OpReg, OpStore, OpBr, OpAmo};
    id_is_br  = (opcode_id_i == OpBr) || (opcode_id_i == OpJalr);
    ex_is_alu = opcode_ex_i inside {OpReg, OpIAlu, OpLui, OpAuipc, OpJal, OpJalr};
    match_ex  = (rd_ex_i != 5'd0) &&
                ((rs1_used && rs1_id_i == rd_ex_i) || (rs2_used && rs2_id_i == rd_ex_i));
    match_mem = (rd_mem_i != 5'd0) &&
                ((rs1_used && rs1_id_i == rd_mem_i) || (rs2_used && rs2_id_i == rd_mem_i));
    hazard    = ((opcode_ex_i == OpLoad) && match_ex) ||
                (id_is_br && ex_is_alu && match_ex) ||
                (id_is_br && (opcode_mem_i == OpLoad) && match_mem);
  end

  always_comb begin
    halted   = (state_q == MonHalt);
    hz_stall = stall_i && !stall_ext_i;
    miss_now = !halted && hazard && !stall_i;
    spur_now = !halted && hz_stall && !hazard;
    // This cycle would be stall number MaxStall+1 of the current run.
    ovr_now  = !halted && hz_stall && (run_len_q >= CntW'(MaxStall));
    new_err  = miss_now || spur_now || ovr_now;

    err_missing_d  = err_missing_q || miss_now;
    err_spurious_d = err_spurious_q || spur_now;
    err_overrun_d  = err_overrun_q || ovr_now;
    first_err_d    = first_err_q;
    if (new_err && !(err_missing_q || err_spurious_q || err_overrun_q)) begin
      first_err_d = cycle_q;
    end

    cycle_d        = cycle_q;
    stall_cycles_d = stall_cycles_q;
    stall_events_d = stall_events_q;
    run_len_d      = run_len_q;
    max_run_d      = max_run_q;
    state_d        = state_q;

    if (!halted) begin
      cycle_d = sat_inc(cycle_q);
      if (stall_i) stall_cycles_d = sat_inc(stall_cycles_q);
      if (hz_stall)     run_len_d = sat_inc(run_len_q);
      else if (!stall_i) run_len_d = '0;
    end

    run_clip = (run_len_d > CntW'(15)) ? 4'hF : run_len_d[3:0];
    if (!halted && run_clip > max_run_q) max_run_d = run_clip;

    unique case (state_q)
      MonIdle: begin
        if (hz_stall) begin
          state_d        = MonRun;
          stall_events_d = sat_inc(stall_events_q);
        end
      end
      MonRun: begin
        if (!stall_i) state_d = MonIdle;
      end
      MonHalt: state_d = MonHalt;
      default: state_d = MonIdle;
    endcase

    if (HaltOnErr && new_err) state_d = MonHalt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= MonIdle;
      err_missing_q  <= 1'b0;
      err_spurious_q <= 1'b0;
      err_overrun_q  <= 1'b0;
      first_err_q    <= '0;
      stall_cycles_q <= '0;
      stall_events_q <= '0;
      cycle_q        <= '0;
      run_len_q      <= '0;
      max_run_q      <= '0;
    end else begin
      state_q        <= state_d;
      err_missing_q  <= err_missing_d;
      err_spurious_q <= err_spurious_d;
      err_overrun_q  <= err_overrun_d;
      first_err_q    <= first_err_d;
      stall_cycles_q <= stall_cycles_d;
      stall_events_q <= stall_events_d;
      cycle_q        <= cycle_d;
      run_len_q      <= run_len_d;
      max_run_q      <= max_run_d;
    end
  end

  assign err_missing_o     = err_missing_q;
  assign err_spurious_o    = err_spurious_q;
  assign err_overrun_o     = err_overrun_q;
  assign err_any_o         = err_missing_q | err_spurious_q | err_overrun_q;
  assign first_err_cycle_o = first_err_q;
  assign stall_cycles_o    = stall_cycles_q;
  assign stall_events_o    = stall_events_q;
  assign max_run_o         = max_run_q;

endmodule

// File: tb/tb_stall_monitor.sv
// Directed self-checking bench for stall_monitor with default parameters.
module tb_stall_monitor;

  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpIAlu = 7'b0010011;
  localparam logic [6:0] OpReg  = 7'b0110011;
  localparam logic [6:0] OpBr   = 7'b1100011;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpJal  = 7'b1101111;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [6:0]  opcode_id_i, opcode_ex_i, opcode_mem_i;
  logic [4:0]  rs1_id_i, rs2_id_i, rd_ex_i, rd_mem_i;
  logic        stall_i, stall_ext_i;
  logic        err_missing_o, err_spurious_o, err_overrun_o, err_any_o;
  logic [15:0] first_err_cycle_o, stall_cycles_o, stall_events_o;
  logic [3:0]  max_run_o;

  int n_checks = 0;
  int n_fail   = 0;

  stall_monitor dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .opcode_id_i       (opcode_id_i),
    .rs1_id_i          (rs1_id_i),
    .rs2_id_i          (rs2_id_i),
    .opcode_ex_i       (opcode_ex_i),
    .rd_ex_i           (rd_ex_i),
    .opcode_mem_i      (opcode_mem_i),
    .rd_mem_i          (rd_mem_i),
    .stall_i           (stall_i),
    .stall_ext_i       (stall_ext_i),
    .err_missing_o     (err_missing_o),
    .err_spurious_o    (err_spurious_o),
    .err_overrun_o     (err_overrun_o),
    .err_any_o         (err_any_o),
    .first_err_cycle_o (first_err_cycle_o),
    .stall_cycles_o    (stall_cycles_o),
    .stall_events_o    (stall_events_o),
    .max_run_o         (max_run_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic [6:0] op_id, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] op_ex, input logic [4:0] rd_ex,
                       input logic [6:0] op_mem, input logic [4:0] rd_mem,
                       input logic stall, input logic ext);
    opcode_id_i  = op_id;
    rs1_id_i     = rs1;
    rs2_id_i     = rs2;
    opcode_ex_i  = op_ex;
    rd_ex_i      = rd_ex;
    opcode_mem_i = op_mem;
    rd_mem_i     = rd_mem;
    stall_i      = stall;
    stall_ext_i  = ext;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(7'd0, 5'd0, 5'd0, 7'd0, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (err_any_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_err_any: got %0b want 0", err_any_o);
    end
    n_checks++;
    if (stall_cycles_o !== 16'd0 || stall_events_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", stall_cycles_o, stall_events_o);
    end
    n_checks++;
    if (max_run_o !== 4'd0 || first_err_cycle_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_max_first: got %0d/%0d want 0/0", max_run_o, first_err_cycle_o);
    end
  endtask

  // Load-use on rs2, correctly stalled once.
  task automatic test_load_use();
    do_reset();
    drive(OpReg, 5'd1, 5'd5, OpLoad, 5'd5, 7'd0, 5'd0, 1'b1, 1'b0);
    step();
    idle();
    step();
    n_checks++;
    if (err_any_o !== 1'b0) begin
      n_fail++; $display("FAIL load_use_err: got %0b want 0", err_any_o);
    end
    n_checks++;
    if (stall_events_o !== 16'd1) begin
      n_fail++; $display("FAIL load_use_events: got %0d want 1", stall_events_o);
    end
    n_checks++;
    if (max_run_o !== 4'd1) begin
      n_fail++; $display("FAIL load_use_max_run: got %0d want 1", max_run_o);
    end
  endtask

  task automatic test_missing();
    do_reset();
    idle();
    step();
    drive(OpReg, 5'd1, 5'd5, OpLoad, 5'd5, 7'd0, 5'd0, 1'b0, 1'b0);
    step();
    n_checks++;
    if (err_missing_o !== 1'b1 || err_any_o !== 1'b1) begin
      n_fail++; $display("FAIL missing_flag: got %0b/%0b want 1/1", err_missing_o, err_any_o);
    end
    n_checks++;
    if (first_err_cycle_o !== 16'd1) begin
      n_fail++; $display("FAIL missing_first_cycle: got %0d want 1", first_err_cycle_o);
    end
    drive(OpReg, 5'd1, 5'd2, 7'd0, 5'd0, 7'd0, 5'd0, 1'b1, 1'b0);
    step();
    step();
    n_checks++;
    if (stall_cycles_o !== 16'd0 || stall_events_o !== 16'd0) begin
      n_fail++; $display("FAIL missing_frozen: got %0d/%0d want 0/0", stall_cycles_o, stall_events_o);
    end
    n_checks++;
    if (first_err_cycle_o !== 16'd1) begin
      n_fail++; $display("FAIL missing_first_kept: got %0d want 1", first_err_cycle_o);
    end
  endtask

  // Branch waits on a load through EX then MEM, then a JALR-on-ALU stall.
  task automatic test_branch();
    do_reset();
    drive(OpBr, 5'd3, 5'd0, OpLoad, 5'd3, 7'd0, 5'd0, 1'b1, 1'b0);
    step();
    drive(OpBr, 5'd3, 5'd0, 7'd0, 5'd0, OpLoad, 5'd3, 1'b1, 1'b0);
    step();
    idle();
    step();
    n_checks++;
    if (err_any_o !== 1'b0) begin
      n_fail++; $display("FAIL branch_mem_err: got %0b want 0", err_any_o);
    end
    n_checks++;
    if (max_run_o !== 4'd2) begin
      n_fail++; $display("FAIL branch_mem_max_run: got %0d want 2", max_run_o);
    end
    drive(OpJalr, 5'd7, 5'd0, OpIAlu, 5'd7, 7'd0, 5'd0, 1'b1, 1'b0);
    step();
    idle();
    step();
    n_checks++;
    if (err_any_o !== 1'b0 || stall_events_o !== 16'd2) begin
      n_fail++; $display("FAIL branch_ex: got err=%0b events=%0d want 0/2", err_any_o, stall_events_o);
    end
    n_checks++;
    if (stall_cycles_o !== 16'd3 || max_run_o !== 4'd2) begin
      n_fail++; $display("FAIL branch_totals: got %0d/%0d want 3/2", stall_cycles_o, max_run_o);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    drive(OpReg, 5'd1, 5'd5, OpLoad, 5'd5, 7'd0, 5'd0, 1'b1, 1'b0);
    step();
    step();
    n_checks++;
    if (err_overrun_o !== 1'b0 || max_run_o !== 4'd2) begin
      n_fail++; $display("FAIL overrun_early: got %0b/%0d want 0/2", err_overrun_o, max_run_o);
    end
    step();
    n_checks++;
    if (err_overrun_o !== 1'b1) begin
      n_fail++; $display("FAIL overrun_flag: got %0b want 1", err_overrun_o);
    end
    n_checks++;
    if (err_missing_o !== 1'b0 || err_spurious_o !== 1'b0) begin
      n_fail++; $display("FAIL overrun_others: got %0b/%0b want 0/0", err_missing_o, err_spurious_o);
    end
    n_checks++;
    if (first_err_cycle_o !== 16'd2 || max_run_o !== 4'd3) begin
      n_fail++; $display("FAIL overrun_first_max: got %0d/%0d want 2/3", first_err_cycle_o, max_run_o);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    drive(OpJal, 5'd4, 5'd0, OpLoad, 5'd4, 7'd0, 5'd0, 1'b1, 1'b0);
    step();
    n_checks++;
    if (err_spurious_o !== 1'b1 || err_missing_o !== 1'b0) begin
      n_fail++; $display("FAIL spurious_flag: got %0b/%0b want 1/0", err_spurious_o, err_missing_o);
    end
    n_checks++;
    if (first_err_cycle_o !== 16'd0) begin
      n_fail++; $display("FAIL spurious_first: got %0d want 0", first_err_cycle_o);
    end
    do_reset();
    drive(OpJal, 5'd4, 5'd0, OpLoad, 5'd4, 7'd0, 5'd0, 1'b1, 1'b1);
    step();
    step();
    idle();
    step();
    n_checks++;
    if (err_any_o !== 1'b0) begin
      n_fail++; $display("FAIL ext_stall_err: got %0b want 0", err_any_o);
    end
    n_checks++;
    if (stall_cycles_o !== 16'd2 || stall_events_o !== 16'd0 || max_run_o !== 4'd0) begin
      n_fail++; $display("FAIL ext_stall_counts: got %0d/%0d/%0d want 2/0/0",
                         stall_cycles_o, stall_events_o, max_run_o);
    end
  endtask

  // Overrun and spurious raised in the same cycle.
  task automatic test_multi_error();
    do_reset();
    drive(OpReg, 5'd1, 5'd5, OpLoad, 5'd5, 7'd0, 5'd0, 1'b1, 1'b0);
    step();
    step();
    drive(OpReg, 5'd1, 5'd5, 7'd0, 5'd0, 7'd0, 5'd0, 1'b1, 1'b0);
    step();
    n_checks++;
    if (err_overrun_o !== 1'b1 || err_spurious_o !== 1'b1 || err_missing_o !== 1'b0) begin
      n_fail++; $display("FAIL multi_flags: got ovr=%0b spur=%0b miss=%0b want 1/1/0",
                         err_overrun_o, err_spurious_o, err_missing_o);
    end
    n_checks++;
    if (first_err_cycle_o !== 16'd2) begin
      n_fail++; $display("FAIL multi_first: got %0d want 2", first_err_cycle_o);
    end
  endtask

  task automatic test_x0_and_mid_reset();
    do_reset();
    drive(OpIAlu, 5'd0, 5'd0, OpLoad, 5'd0, 7'd0, 5'd0, 1'b0, 1'b0);
    step();
    n_checks++;
    if (err_any_o !== 1'b0) begin
      n_fail++; $display("FAIL x0_no_hazard: got %0b want 0", err_any_o);
    end
    drive(OpReg, 5'd1, 5'd5, OpLoad, 5'd5, 7'd0, 5'd0, 1'b1, 1'b0);
    step();
    rst_ni = 1'b0;
    step();
    n_checks++;
    if (err_any_o !== 1'b0 || stall_cycles_o !== 16'd0 || stall_events_o !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset_clear: got err=%0b cyc=%0d ev=%0d want 0/0/0",
                         err_any_o, stall_cycles_o, stall_events_o);
    end
    n_checks++;
    if (max_run_o !== 4'd0 || first_err_cycle_o !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset_max_first: got %0d/%0d want 0/0", max_run_o, first_err_cycle_o);
    end
    rst_ni = 1'b1;
    idle();
    step();
    drive(OpReg, 5'd1, 5'd5, OpLoad, 5'd5, 7'd0, 5'd0, 1'b1, 1'b0);
    step();
    n_checks++;
    if (stall_events_o !== 16'd1 || max_run_o !== 4'd1 || err_any_o !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_run: got ev=%0d max=%0d err=%0b want 1/1/0",
                         stall_events_o, max_run_o, err_any_o);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_missing();
    test_branch();
    test_overrun();
    test_spurious();
    test_multi_error();
    test_x0_and_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
